// File: rtl/stack_push_pop_unit.sv
// PUSH/POP sequencer in front of the ESP register: runs one memory beat
// and emits the ESP update (esp_wr_sel/esp_wr_data) plus popped data.
//
// Ports:
//   clock_5, reset          : clock, synchronous active-high reset
//   op_valid/op_push/op_data: operation request, op_ready = idle
//   esp                     : current stack pointer, sampled at accept
//   mem_*                   : single-beat memory access, mem_ack strobe
//   esp_wr_sel/esp_wr_data  : ESP register write (4'h1 = load)
//   pop_valid/pop_data      : popped word, one-cycle strobe
//   fault                   : sticky; misalignment or ack timeout
module stack_push_pop_unit #(
   parameter int unsigned STEP     = 4,
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic        clock_5,
   input  logic        reset,
   input  logic        op_valid,
   input  logic        op_push,
   input  logic [31:0] op_data,
   output logic        op_ready,
   input  logic [31:0] esp,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [3:0]  esp_wr_sel,
   output logic [31:0] esp_wr_data,
   output logic        pop_valid,
   output logic [31:0] pop_data,
   output logic        fault
);

   localparam int unsigned CW = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);
   localparam logic [31:0] STEP_W = 32'(STEP);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WB,
      S_FAULT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic          push_q, push_d;
   logic [31:0]   new_esp_q, new_esp_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]    esp_wr_sel_q, esp_wr_sel_d;
   logic [31:0]   esp_wr_data_q, esp_wr_data_d;
   logic          pop_valid_q, pop_valid_d;
   logic [31:0]   pop_data_q, pop_data_d;
   logic          fault_q, fault_d;

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      push_d        = push_q;
      new_esp_d     = new_esp_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      esp_wr_sel_d  = esp_wr_sel_q;
      esp_wr_data_d = esp_wr_data_q;
      pop_valid_d   = pop_valid_q;
      pop_data_d    = pop_data_q;
      fault_d       = fault_q;
      unique case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               if (esp[1:0] != 2'b00) begin
                  state_d = S_FAULT;
                  fault_d = 1'b1;
               end else begin
                  push_d    = op_push;
                  mem_req_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = S_REQ;
                  if (op_push) begin
                     mem_we_d    = 1'b1;
                     mem_addr_d  = esp - STEP_W;
                     mem_wdata_d = op_data;
                     new_esp_d   = esp - STEP_W;
                  end else begin
                     mem_we_d   = 1'b0;
                     mem_addr_d = esp;
                     new_esp_d  = esp + STEP_W;
                  end
               end
            end
         end
         S_REQ: begin
            // ack takes priority over a timeout on the same edge
            if (mem_ack) begin
               mem_req_d     = 1'b0;
               mem_we_d      = 1'b0;
               esp_wr_sel_d  = 4'h1;
               esp_wr_data_d = new_esp_q;
               if (!push_q) begin
                  pop_data_d  = mem_rdata;
                  pop_valid_d = 1'b1;
               end
               state_d = S_WB;
            end else if (cnt_inc == WAIT_LIM) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               fault_d   = 1'b1;
               state_d   = S_FAULT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_WB: begin
            esp_wr_sel_d = 4'h0;
            pop_valid_d  = 1'b0;
            state_d      = S_IDLE;
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_5) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         push_q        <= 1'b0;
         new_esp_q     <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         esp_wr_sel_q  <= 4'h0;
         esp_wr_data_q <= '0;
         pop_valid_q   <= 1'b0;
         pop_data_q    <= '0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         push_q        <= push_d;
         new_esp_q     <= new_esp_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         esp_wr_sel_q  <= esp_wr_sel_d;
         esp_wr_data_q <= esp_wr_data_d;
         pop_valid_q   <= pop_valid_d;
         pop_data_q    <= pop_data_d;
         fault_q       <= fault_d;
      end
   end

   assign op_ready    = (state_q == S_IDLE);
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign esp_wr_sel  = esp_wr_sel_q;
   assign esp_wr_data = esp_wr_data_q;
   assign pop_valid   = pop_valid_q;
   assign pop_data    = pop_data_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_stack_push_pop_unit.sv
// Bench for stack_push_pop_unit: directed scenarios plus a random
// push/pop run against a stack model (ESP value + word memory).
module tb_stack_push_pop_unit;

   localparam logic [31:0] STEP = 32'd4;

   logic        clock_5 = 1'b0;
   logic        reset;
   logic        op_valid;
   logic        op_push;
   logic [31:0] op_data;
   logic        op_ready;
   logic [31:0] esp;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [3:0]  esp_wr_sel;
   logic [31:0] esp_wr_data;
   logic        pop_valid;
   logic [31:0] pop_data;
   logic        fault;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mem_m [logic [31:0]];
   logic [31:0] esp_m;
   logic [31:0] last_pop_m;

   stack_push_pop_unit dut (
      .clock_5    (clock_5),
      .reset      (reset),
      .op_valid   (op_valid),
      .op_push    (op_push),
      .op_data    (op_data),
      .op_ready   (op_ready),
      .esp        (esp),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .esp_wr_sel (esp_wr_sel),
      .esp_wr_data(esp_wr_data),
      .pop_valid  (pop_valid),
      .pop_data   (pop_data),
      .fault      (fault)
   );

   always #5 clock_5 = ~clock_5;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock_5);
      reset = 1'b0;
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_req"}, mem_req, 0);
      chk({tag, "_we"}, mem_we, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
      chk({tag, "_sel"}, esp_wr_sel, 0);
      chk({tag, "_wrdata"}, esp_wr_data, 0);
      chk({tag, "_popv"}, pop_valid, 0);
      chk({tag, "_popd"}, pop_data, 0);
      chk({tag, "_fault"}, fault, 0);
      chk({tag, "_ready"}, op_ready, 1);
   endtask

   // One full operation: accept, `waits` no-ack REQ edges, ack, WB.
   task automatic run_op(input bit push, input logic [31:0] e,
                         input logic [31:0] d, input int waits,
                         input logic [31:0] rd,
                         output logic [31:0] got_new);
      logic [31:0] exp_addr;
      logic [31:0] exp_new;
      exp_addr = push ? e - STEP : e;
      exp_new  = push ? e - STEP : e + STEP;
      chk("pre_ready", op_ready, 1);
      op_valid = 1'b1;
      op_push  = push;
      op_data  = d;
      esp      = e;
      mem_ack  = 1'b0;
      @(negedge clock_5);
      op_valid = 1'b0;
      esp      = $urandom;
      op_data  = $urandom;
      for (int i = 0; i <= waits; i++) begin
         chk("req_hi", mem_req, 1);
         chk("req_we", mem_we, push);
         chk("req_addr", mem_addr, exp_addr);
         if (push) chk("req_wdata", mem_wdata, d);
         chk("req_ready", op_ready, 0);
         chk("req_sel", esp_wr_sel, 0);
         if (i < waits) @(negedge clock_5);
      end
      mem_ack   = 1'b1;
      mem_rdata = rd;
      @(negedge clock_5);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      got_new   = esp_wr_data;
      chk("wb_req", mem_req, 0);
      chk("wb_sel", esp_wr_sel, 4'h1);
      chk("wb_data", esp_wr_data, exp_new);
      chk("wb_popv", pop_valid, !push);
      if (!push) chk("wb_popd", pop_data, rd);
      chk("wb_ready", op_ready, 0);
      @(negedge clock_5);
      chk("end_sel", esp_wr_sel, 0);
      chk("end_popv", pop_valid, 0);
      chk("end_ready", op_ready, 1);
      chk("end_fault", fault, 0);
   endtask

   initial begin
      logic [31:0] nv;
      logic [31:0] rd;
      bit          p;
      reset     = 1'b1;
      op_valid  = 1'b0;
      op_push   = 1'b0;
      op_data   = '0;
      esp       = '0;
      mem_rdata = '0;
      mem_ack   = 1'b0;
      repeat (2) @(negedge clock_5);
      reset = 1'b0;
      chk_idle_zero("rst");

      // 1: PUSH, ack on first REQ edge
      run_op(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0, nv);
      chk("t1_new", nv, 32'h0000_0FFC);
      chk("t1_popd_hold", pop_data, 0);

      // 2: POP with 3 wait cycles
      run_op(1'b0, 32'h0000_0FFC, 32'h0, 3, 32'h1234_5678, nv);
      chk("t2_new", nv, 32'h0000_1000);
      chk("t2_popd", pop_data, 32'h1234_5678);

      // 3: wraparound
      run_op(1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1, 32'h0, nv);
      chk("t3_push_new", nv, 32'hFFFF_FFFC);
      run_op(1'b0, 32'hFFFF_FFFC, 32'h0, 0, 32'hCAFE_F00D, nv);
      chk("t3_pop_new", nv, 32'h0000_0000);

      // 4b: ack exactly on the 15th REQ edge
      run_op(1'b0, 32'h0000_2000, 32'h0, 14, 32'h0BAD_CAFE, nv);
      chk("t4b_new", nv, 32'h0000_2004);

      // 4a: timeout
      op_valid = 1'b1;
      op_push  = 1'b0;
      esp      = 32'h0000_3000;
      @(negedge clock_5);
      op_valid = 1'b0;
      repeat (14) @(negedge clock_5);
      chk("t4_req_before", mem_req, 1);
      chk("t4_fault_before", fault, 0);
      @(negedge clock_5);
      chk("t4_fault", fault, 1);
      chk("t4_req", mem_req, 0);
      chk("t4_ready", op_ready, 0);
      chk("t4_sel", esp_wr_sel, 0);
      op_valid = 1'b1;
      op_push  = 1'b1;
      esp      = 32'h0000_4000;
      repeat (3) begin
         @(negedge clock_5);
         chk("t4_ign_req", mem_req, 0);
         chk("t4_ign_sel", esp_wr_sel, 0);
         chk("t4_ign_fault", fault, 1);
      end
      op_valid = 1'b0;
      do_reset();
      chk_idle_zero("t4_rst");

      // 5: misaligned ESP
      op_valid = 1'b1;
      op_push  = 1'b1;
      esp      = 32'h0000_0102;
      @(negedge clock_5);
      op_valid = 1'b0;
      chk("t5_fault", fault, 1);
      chk("t5_req", mem_req, 0);
      chk("t5_sel", esp_wr_sel, 0);
      chk("t5_ready", op_ready, 0);
      @(negedge clock_5);
      chk("t5_req2", mem_req, 0);
      do_reset();
      chk_idle_zero("t5_rst");

      // 6: reset mid-REQ, then stray ack, then a normal PUSH
      op_valid = 1'b1;
      op_push  = 1'b1;
      op_data  = 32'h1111_2222;
      esp      = 32'h0000_8000;
      @(negedge clock_5);
      op_valid = 1'b0;
      chk("t6_req", mem_req, 1);
      do_reset();
      chk_idle_zero("t6_rst");
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_0000;
      @(negedge clock_5);
      mem_ack = 1'b0;
      chk_idle_zero("t6_stray");
      run_op(1'b1, 32'h0000_8000, 32'h3333_4444, 2, 32'h0, nv);
      chk("t6_new", nv, 32'h0000_7FFC);

      // random push/pop run against a stack model
      esp_m      = {$urandom} & 32'hFFFF_FFFC;
      last_pop_m = pop_data;
      for (int n = 0; n < 40; n++) begin
         logic [31:0] d;
         logic [31:0] a;
         int          w;
         p = ($urandom_range(0, 1) == 1);
         d = $urandom;
         w = $urandom_range(0, 5);
         if (p) begin
            a = esp_m - STEP;
            mem_m[a] = d;
            rd = $urandom;
         end else begin
            a = esp_m;
            rd = mem_m.exists(a) ? mem_m[a] : $urandom;
            last_pop_m = rd;
         end
         run_op(p, esp_m, d, w, rd, nv);
         esp_m = p ? esp_m - STEP : esp_m + STEP;
         chk("rnd_esp", nv, esp_m);
         chk("rnd_popd", pop_data, last_pop_m);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
